// File: rtl/rmt_meta_pkg.sv
// Metadata field positions shared between the metadata ALU and its consumers.
package rmt_meta_pkg;
  localparam int DISCARD_BIT  = 128;
  localparam int DST_PORT_LSB = 24;
  localparam int DST_PORT_W   = 8;
  localparam int NTID_LSB     = 350;
  localparam int NTID_W       = 6;
endpackage

// File: rtl/meta_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push into a full FIFO is accepted only alongside a pop.
module meta_sync_fifo #(
  parameter int WIDTH = 356,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             push_en;
  logic             pop_en;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign count   = wptr - rptr;
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);
  assign pop_dat = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_en) wptr <= wptr + 1'b1;
      if (pop_en)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wptr[AW-1:0]] <= push_dat;
  end
endmodule

// File: rtl/meta_dispatch.sv
// Buffers un-backpressured metadata pulses, drops discarded entries, forwards the rest on valid/ready.
// META_DISPATCH_STATS_EN enables saturating drop/overflow counters; otherwise they read 0.
module meta_dispatch
  import rmt_meta_pkg::*;
#(
  parameter int META_LEN   = 256,
  parameter int COMP_LEN   = 100,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [META_LEN+COMP_LEN-1:0] comp_meta_data_in,
  input  logic                         comp_meta_data_valid_in,
  output logic [META_LEN+COMP_LEN-1:0] meta_data_out,
  output logic [DST_PORT_W-1:0]        dst_port_out,
  output logic [NTID_W-1:0]            next_table_id_out,
  output logic                         meta_valid_out,
  input  logic                         meta_ready_in,
  output logic                         overflow_pulse,
  output logic [CNT_W-1:0]             drop_cnt,
  output logic [CNT_W-1:0]             ovf_cnt
);
  localparam int W  = META_LEN + COMP_LEN;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DECODE, OUT} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   held;
  logic [W-1:0]   fifo_dat;
  logic           fifo_full;
  logic           fifo_empty;
  logic [AW:0]    fifo_level_unused;
  logic           pop;
  logic           push_ok;
  logic           lost;

  assign pop     = (state == IDLE) && !fifo_empty;
  assign push_ok = comp_meta_data_valid_in && (!fifo_full || pop);
  assign lost    = comp_meta_data_valid_in && fifo_full && !pop;

  meta_sync_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_ok),
    .push_dat (comp_meta_data_in),
    .pop      (pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_level_unused)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = DECODE;
      DECODE:  state_nxt = held[DISCARD_BIT] ? IDLE : OUT;
      OUT:     if (meta_ready_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      held              <= '0;
      meta_data_out     <= '0;
      dst_port_out      <= '0;
      next_table_id_out <= '0;
      meta_valid_out    <= 1'b0;
      overflow_pulse    <= 1'b0;
    end else begin
      state          <= state_nxt;
      overflow_pulse <= lost;
      if (pop) held <= fifo_dat;
      if (state == DECODE && !held[DISCARD_BIT]) begin
        meta_data_out     <= held;
        dst_port_out      <= held[DST_PORT_LSB +: DST_PORT_W];
        next_table_id_out <= held[NTID_LSB +: NTID_W];
        meta_valid_out    <= 1'b1;
      end else if (state == OUT && meta_ready_in) begin
        meta_valid_out <= 1'b0;
      end
    end
  end

`ifdef META_DISPATCH_STATS_EN
  logic drop_evt;
  assign drop_evt = (state == DECODE) && held[DISCARD_BIT];

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      if (drop_evt && (drop_cnt != {CNT_W{1'b1}})) drop_cnt <= drop_cnt + 1'b1;
      if (lost && (ovf_cnt != {CNT_W{1'b1}}))      ovf_cnt  <= ovf_cnt + 1'b1;
    end
  end
`else
  assign drop_cnt = '0;
  assign ovf_cnt  = '0;
`endif
endmodule
